bcd_timer_counter: RTL and testbench
====================================

BCD_TIMER_COUNTER -- requirements
Module: bcd_timer_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per count step (>=1).
REQ-003 SHALL have parameter SATURATE, default 1, 1 = hold at limit, 0 = wrap at limit.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of count, prescaler and ovf.
REQ-007 SHALL have port en  input  1  count enable; prescaler and count frozen when low.
REQ-008 SHALL have port up_dn  input  1  direction, 1 = increment, 0 = decrement.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0].
REQ-011 SHALL have port count  output  4*DIGITS  current BCD value, digit i in bits [4i+3:4i].
REQ-012 SHALL have port tick  output  1  one-cycle pulse, high for the cycle after each count step.
REQ-013 SHALL have port tc  output  1  one-cycle pulse, terminal count reached or crossed on a step.
REQ-014 SHALL have port ovf  output  1  sticky flag, set on any limit event, cleared by clr or rst.

Function
REQ-015 SHALL clock every register from clk only; no derived or ripple clocks.
REQ-016 SHALL apply priority clr > load > step in any cycle.
REQ-017 SHALL run an internal prescaler 0..PRESCALE-1 that advances only when en=1 and wraps to 0.
REQ-018 SHALL perform one count step on the rising edge where en=1 and prescaler = PRESCALE-1.
REQ-019 SHALL, on an up step, add 1 with decimal carry (digit 9 -> 0, +1 to next digit).
REQ-020 SHALL, on a down step, subtract 1 with decimal borrow (digit 0 -> 9, -1 from next digit).
REQ-021 SHALL treat the up limit as all digits 9 and the down limit as all digits 0.
REQ-022 SHALL, with SATURATE=1 and a step requested at a limit in that direction, hold count unchanged, pulse tc, set ovf.
REQ-023 SHALL, with SATURATE=0 and a step at a limit, wrap (all-9 -> 0 up, 0 -> all-9 down), pulse tc, set ovf.
REQ-024 SHALL also pulse tc (without setting ovf) when a step lands exactly on the limit in the current direction.
REQ-025 SHALL, on load, replace each digit with its load_val digit, clamping any digit >9 to 9, and reset the prescaler to 0.
REQ-026 SHALL produce tick and tc as registered outputs: high for exactly the one cycle following the stepping edge.
REQ-027 SHALL not generate tick on load or clr cycles, and a step is discarded if load or clr is high the same cycle.
REQ-028 SHALL sample up_dn on the stepping edge only; direction changes between steps take effect on the next step.
REQ-029 SHALL, with PRESCALE=1, step on every enabled cycle.

Reset
REQ-030 SHALL, on rst high, immediately force count=0, prescaler=0, tick=0, tc=0, ovf=0, independent of clk.
REQ-031 SHALL, with rst deasserted mid-prescale, restart counting from prescaler=0 on the first edge after release.
REQ-032 SHALL perform clr identically to rst but synchronously.

Verification (DIGITS=4, PRESCALE=3 unless stated)
REQ-033 SHALL cover: rst, en=1, up_dn=1 for 30 cycles -> count 0x0010, tick every 3rd cycle, tc/ovf never high.
REQ-034 SHALL cover: load 0x0099, then 1 up step -> count 0x0100, tick pulses once, no tc.
REQ-035 SHALL cover: SATURATE=1, load 0x9998, 2 up steps -> 0x9999 with tc, then hold at 0x9999 with tc and ovf=1.
REQ-036 SHALL cover: SATURATE=0, load 0x0000, up_dn=0, 1 step -> count 0x9999, tc pulse, ovf=1.
REQ-037 SHALL cover: load_val 0xA3F1 -> count 0x9391; clr asserted together with load -> count 0x0000.
REQ-038 SHALL cover: rst pulsed asynchronously between edges during counting -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/bcd_timer_counter.sv
// Prescaled BCD up/down counter with a saturate or wrap policy at the limits.
// tick and tc are registered pulses; ovf is sticky until clr or rst.
module bcd_timer_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  tc,
  output logic                  ovf
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  ALL9     = {DIGITS{4'h9}};

  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_count;
  logic          r_tick;
  logic          r_tc;
  logic          r_ovf;

  logic [W-1:0]  w_inc;
  logic [W-1:0]  w_dec;
  logic [W-1:0]  w_load_clamped;
  logic [W-1:0]  w_next;
  logic [W-1:0]  w_limit;
  logic [W-1:0]  w_wrap;
  logic          w_cy;
  logic          w_bw;
  logic          w_at_limit;
  logic          w_hit;

  // Ripple decimal carry/borrow through the digits, LSD first.
  always_comb begin
    w_inc          = r_count;
    w_dec          = r_count;
    w_load_clamped = '0;
    w_cy           = 1'b1;
    w_bw           = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cy) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_cy            = 1'b0;
        end
      end
      if (w_bw) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_bw            = 1'b0;
        end
      end
      w_load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    w_limit    = up_dn ? ALL9 : '0;
    w_wrap     = up_dn ? '0 : ALL9;
    w_at_limit = (r_count == w_limit);
    if (w_at_limit) begin
      w_next = SATURATE ? r_count : w_wrap;
    end else begin
      w_next = up_dn ? w_inc : w_dec;
    end
    w_hit = w_at_limit || (w_next == w_limit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      if (clr) begin
        r_presc <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (load) begin
        r_presc <= '0;
        r_count <= w_load_clamped;
      end else if (en) begin
        if (r_presc == PRE_LAST) begin
          r_presc <= '0;
          r_count <= w_next;
          r_tick  <= 1'b1;
          r_tc    <= w_hit;
          if (w_at_limit) r_ovf <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Bench for bcd_timer_counter: saturating and wrapping instances share stimulus
// and are checked every cycle against an integer-arithmetic model.
module tb_bcd_timer_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 3;
  localparam int MAXV     = 9999;

  logic        clk = 1'b0;
  logic        rst, clr, en, up_dn, load;
  logic [15:0] load_val;
  logic [15:0] count_s, count_w;
  logic        tick_s, tc_s, ovf_s, tick_w, tc_w, ovf_w;

  int checks = 0;
  int errors = 0;

  bcd_timer_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count_s), .tick(tick_s), .tc(tc_s), .ovf(ovf_s));

  bcd_timer_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count_w), .tick(tick_w), .tc(tc_w), .ovf(ovf_w));

  always #5 clk = ~clk;

  // Model state: index 0 = saturating instance, 1 = wrapping instance.
  int m_cnt [2];
  bit m_tick[2];
  bit m_tc  [2];
  bit m_ovf [2];
  int m_pre;

  initial begin
    m_pre = 0;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_tick[s] = 0; m_tc[s] = 0; m_ovf[s] = 0;
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_decimal(input logic [15:0] lv);
    int v, d, w;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre = 0;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] = 0; m_tick[s] = 0; m_tc[s] = 0; m_ovf[s] = 0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        m_tick[s] = 0; m_tc[s] = 0;
      end
      if (clr) begin
        m_pre = 0;
        for (int s = 0; s < 2; s++) begin
          m_cnt[s] = 0; m_ovf[s] = 0;
        end
      end else if (load) begin
        m_pre = 0;
        for (int s = 0; s < 2; s++) m_cnt[s] = load_decimal(load_val);
      end else if (en) begin
        if (m_pre == PRESCALE - 1) begin
          m_pre = 0;
          for (int s = 0; s < 2; s++) begin
            m_tick[s] = 1;
            if (up_dn) begin
              if (m_cnt[s] == MAXV) begin
                m_tc[s] = 1; m_ovf[s] = 1;
                m_cnt[s] = (s == 0) ? MAXV : 0;
              end else begin
                m_cnt[s] = m_cnt[s] + 1;
                if (m_cnt[s] == MAXV) m_tc[s] = 1;
              end
            end else begin
              if (m_cnt[s] == 0) begin
                m_tc[s] = 1; m_ovf[s] = 1;
                m_cnt[s] = (s == 0) ? 0 : MAXV;
              end else begin
                m_cnt[s] = m_cnt[s] - 1;
                if (m_cnt[s] == 0) m_tc[s] = 1;
              end
            end
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("count_sat", 32'(count_s), 32'(to_bcd(m_cnt[0])));
    chk("tick_sat",  32'(tick_s),  32'(m_tick[0]));
    chk("tc_sat",    32'(tc_s),    32'(m_tc[0]));
    chk("ovf_sat",   32'(ovf_s),   32'(m_ovf[0]));
    chk("count_wrap", 32'(count_w), 32'(to_bcd(m_cnt[1])));
    chk("tick_wrap",  32'(tick_w),  32'(m_tick[1]));
    chk("tc_wrap",    32'(tc_w),    32'(m_tc[1]));
    chk("ovf_wrap",   32'(ovf_w),   32'(m_ovf[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    cyc(2);
    chk("lit_rst_count", 32'(count_s), 32'h0);
    chk("lit_rst_flags", 32'({tick_s, tc_s, ovf_s}), 32'h0);

    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    cyc(30);
    chk("lit_up30_count", 32'(count_s), 32'h0010);
    chk("lit_up30_tc_ovf", 32'({tc_s, ovf_s, tc_w, ovf_w}), 32'h0);

    load = 1'b1; load_val = 16'h0099; cyc(1); load = 1'b0;
    chk("lit_load99_notick", 32'(tick_s), 32'h0);
    cyc(3);
    chk("lit_carry_count", 32'(count_s), 32'h0100);
    chk("lit_carry_tick_tc", 32'({tick_s, tc_s}), 32'h2);

    load = 1'b1; load_val = 16'h9998; cyc(1); load = 1'b0;
    cyc(3);
    chk("lit_land9999_count", 32'(count_s), 32'h9999);
    chk("lit_land9999_tc_ovf", 32'({tc_s, ovf_s}), 32'h2);
    cyc(3);
    chk("lit_sat_hold_count", 32'(count_s), 32'h9999);
    chk("lit_sat_hold_tc_ovf", 32'({tc_s, ovf_s}), 32'h3);
    chk("lit_wrap_up_count", 32'(count_w), 32'h0000);
    chk("lit_wrap_up_ovf", 32'(ovf_w), 32'h1);

    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("lit_clr_ovf", 32'({ovf_s, ovf_w}), 32'h0);

    up_dn = 1'b0; load = 1'b1; load_val = 16'h0000; cyc(1); load = 1'b0;
    cyc(3);
    chk("lit_wrap_dn_count", 32'(count_w), 32'h9999);
    chk("lit_wrap_dn_tc_ovf", 32'({tc_w, ovf_w}), 32'h3);
    chk("lit_sat_dn_count", 32'(count_s), 32'h0000);

    en = 1'b0; load = 1'b1; load_val = 16'hA3F1; cyc(1);
    chk("lit_clamp_count", 32'(count_s), 32'h9391);
    clr = 1'b1; cyc(1);
    chk("lit_clr_over_load", 32'(count_s), 32'h0000);
    clr = 1'b0; load = 1'b0;

    en = 1'b1; up_dn = 1'b1; cyc(7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_async_rst_count", 32'({count_s, count_w}), 32'h0);
    chk("lit_async_rst_flags", 32'({tick_s, tc_s, ovf_s, tick_w, tc_w, ovf_w}), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      #1;
      rst  = ($urandom_range(0, 299) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 24) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      case ($urandom_range(0, 4))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        2: load_val = 16'h9997;
        3: load_val = 16'h0002;
        default: load_val = 16'($urandom);
      endcase
    end
    @(negedge clk);
    #1 rst = 1'b0; clr = 1'b0; load = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
